// File: rtl/gpr_arb_pkg.sv
// Shared constants and helpers for the GPR writeback arbiter.
//   N_REQ_DEFAULT : default number of writeback requesters
//   REG_ZERO      : hardwired-zero register (writes to it are meaningless)
//   REG_OVF       : register whose bit 0 the file sets on an overflow entry
//   onehot_dec    : address -> one-hot register decode, sized for the widest
//                   supported address; callers truncate to 2**AW bits.
package gpr_arb_pkg;

    localparam int         N_REQ_DEFAULT = 3;
    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam logic [4:0] REG_OVF       = 5'd30;

    localparam int AW_MAX  = 8;
    localparam int DEC_MAX = 1 << AW_MAX;

    function automatic logic [DEC_MAX-1:0] onehot_dec(input logic [AW_MAX-1:0] addr);
        logic [DEC_MAX-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/gpr_wb_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority index for this cycle
//   grant     : one-hot grant (zero when nothing requests)
//   grant_idx : binary index of the granted requester
//   any_grant : at least one request present
// The request vector is duplicated so a search starting at ptr can wrap
// without modular arithmetic: bits below ptr in the lower copy are masked,
// and the lowest surviving bit of the double-width vector is the winner.
module rr_picker #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any_grant
);

    localparam int W2 = 2 * N;

    logic [W2-1:0] dbl;
    logic [W2-1:0] below;
    logic [W2-1:0] masked;
    int            sel;

    always_comb begin
        dbl    = {req, req};
        below  = (W2'(1) << ptr) - W2'(1);
        masked = dbl & ~below;
        sel    = 0;
        // Descending scan: the last hit written is the lowest set bit.
        for (int j = W2 - 1; j >= 0; j--) begin
            if (masked[j]) sel = j;
        end
        any_grant = |req;
        grant_idx = (sel >= N) ? PW'(sel - N) : PW'(sel);
        grant     = any_grant ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Register-file write-port arbiter.
// Each writeback source owns a 1-entry holding slot; a round-robin picker
// moves one slot per cycle into a registered stage that drives the register
// file write controls directly.
//   clk, reset        : clock, async active-high reset
//   req_valid/ready   : per-requester handshake into the holding slots
//   req_addr/data/ovf : flattened per-requester write payload
//   reg_write_out, write_reg_out, write_data_out, overflow_out : write port
//   pending_mask      : registers with a write still in flight (bit 0 never)
//   busy              : any slot or the write stage is occupied
module gpr_wb_arbiter
    import gpr_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*AW-1:0]   req_addr,
    input  logic [N_REQ*DW-1:0]   req_data,
    input  logic [N_REQ-1:0]      req_ovf,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  reg_write_out,
    output logic [AW-1:0]         write_reg_out,
    output logic [DW-1:0]         write_data_out,
    output logic                  overflow_out,
    output logic [(1<<AW)-1:0]    pending_mask,
    output logic                  busy
);

    localparam int PW   = $clog2(N_REQ);
    localparam int NREG = 1 << AW;

    logic [N_REQ-1:0]         slot_valid;
    logic [N_REQ-1:0]         slot_ovf;
    logic [N_REQ-1:0][AW-1:0] slot_addr;
    logic [N_REQ-1:0][DW-1:0] slot_data;

    logic [N_REQ-1:0][AW-1:0] addr_in;
    logic [N_REQ-1:0][DW-1:0] data_in;
    logic [N_REQ-1:0]         load;

    logic [PW-1:0]            rr_ptr;
    logic [N_REQ-1:0]         grant;
    logic [PW-1:0]            grant_idx;
    logic                     any_grant;
    logic [NREG-1:0]          pm;

    rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
        .req       (slot_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // A slot being drained this cycle can take a new entry on the same edge.
    assign req_ready = ~slot_valid | grant;

    // Writes to r0 without overflow have no architectural effect: handshake
    // them but never occupy a slot.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_in[i] = req_addr[i*AW +: AW];
            data_in[i] = req_data[i*DW +: DW];
            load[i]    = req_valid[i] & req_ready[i]
                       & ((addr_in[i] != AW'(REG_ZERO)) | req_ovf[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
            slot_ovf   <= '0;
            slot_addr  <= '0;
            slot_data  <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (load[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_addr[i]  <= addr_in[i];
                    slot_data[i]  <= data_in[i];
                    slot_ovf[i]   <= req_ovf[i];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Write stage: enable/overflow pulse per grant, address/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr         <= '0;
            reg_write_out  <= 1'b0;
            write_reg_out  <= '0;
            write_data_out <= '0;
            overflow_out   <= 1'b0;
        end else begin
            reg_write_out <= any_grant;
            overflow_out  <= any_grant & slot_ovf[grant_idx];
            if (any_grant) begin
                write_reg_out  <= slot_addr[grant_idx];
                write_data_out <= slot_data[grant_idx];
                rr_ptr         <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_comb begin
        pm = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (slot_valid[i]) begin
                pm = pm | NREG'(onehot_dec(AW_MAX'(slot_addr[i])));
                if (slot_ovf[i]) pm = pm | NREG'(onehot_dec(AW_MAX'(REG_OVF)));
            end
        end
        if (reg_write_out) begin
            pm = pm | NREG'(onehot_dec(AW_MAX'(write_reg_out)));
            if (overflow_out) pm = pm | NREG'(onehot_dec(AW_MAX'(REG_OVF)));
        end
        // r0 is never a real hazard, even for an overflow-only entry.
        pm[0] = 1'b0;
    end

    assign pending_mask = pm;
    assign busy         = (|slot_valid) | reg_write_out;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ovf;
    logic [N-1:0]      req_ready;
    logic              reg_write_out;
    logic [AW-1:0]     write_reg_out;
    logic [DW-1:0]     write_data_out;
    logic              overflow_out;
    logic [(1<<AW)-1:0] pending_mask;
    logic              busy;

    gpr_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ovf        (req_ovf),
        .req_ready      (req_ready),
        .reg_write_out  (reg_write_out),
        .write_reg_out  (write_reg_out),
        .write_data_out (write_data_out),
        .overflow_out   (overflow_out),
        .pending_mask   (pending_mask),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          o;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad   = 0;
    int  wcount[32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic o);
        wr_t e;
        e.a = a; e.d = d; e.o = o;
        exp_q.push_back(e);
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic o);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req_ovf[i]           = o;
    endtask

    function automatic logic [DW-1:0] dat(input int i, input int n);
        return 32'hC000_0000 | DW'(i << 8) | DW'(n);
    endfunction

    // Scoreboard: every write-port pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && reg_write_out) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_write observed addr=%0d expected none", write_reg_out);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(write_reg_out), 64'(mon_e.a));
                chk("wr_data", 64'(write_data_out), 64'(mon_e.d));
                chk("wr_ovf", 64'(overflow_out), 64'(mon_e.o));
                wcount[write_reg_out]++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] acc;
        int n[N];
        int n0, n2;

        req_valid = '0; req_addr = '0; req_data = '0; req_ovf = '0;
        foreach (wcount[i]) wcount[i] = 0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready), 64'(3'b111));
        chk("rst_we",    64'(reg_write_out), 64'd0);
        chk("rst_wreg",  64'(write_reg_out), 64'd0);
        chk("rst_wdata", 64'(write_data_out), 64'd0);
        chk("rst_ovf",   64'(overflow_out), 64'd0);
        chk("rst_pm",    64'(pending_mask), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Single write: visible on the port two edges after the handshake.
        set_req(0, 5'd5, 32'h1234_5678, 1'b0);
        req_valid = 3'b001;
        push(5'd5, 32'h1234_5678, 1'b0);
        @(negedge clk);
        chk("t1_ready", 64'(req_ready), 64'(3'b111));
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("t1_we_e0",   64'(reg_write_out), 64'd0);
        chk("t1_pm5_e0",  64'(pending_mask[5]), 64'd1);
        chk("t1_busy_e0", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_we_e1",    64'(reg_write_out), 64'd1);
        chk("t1_wreg_e1",  64'(write_reg_out), 64'd5);
        chk("t1_wdata_e1", 64'(write_data_out), 64'h1234_5678);
        chk("t1_pm5_e1",   64'(pending_mask[5]), 64'd1);
        @(negedge clk);
        chk("t1_we_e2",   64'(reg_write_out), 64'd0);
        chk("t1_pm5_e2",  64'(pending_mask[5]), 64'd0);
        chk("t1_busy_e2", 64'(busy), 64'd0);

        // Reset to return rr_ptr to 0, then three simultaneous requesters.
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        set_req(0, 5'd1, 32'hA1, 1'b0);
        set_req(1, 5'd2, 32'hA2, 1'b0);
        set_req(2, 5'd3, 32'hA3, 1'b0);
        req_valid = 3'b111;
        push(5'd1, 32'hA1, 1'b0);
        push(5'd2, 32'hA2, 1'b0);
        push(5'd3, 32'hA3, 1'b0);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("t3_we_e0", 64'(reg_write_out), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_seq_we",   64'(reg_write_out), 64'd1);
            chk("t3_seq_addr", 64'(write_reg_out), 64'(k + 1));
        end
        @(negedge clk);
        chk("t3_busy_end", 64'(busy), 64'd0);

        // Sustained load: grants cycle 0,1,2 with no bubbles.
        @(posedge clk); #1;
        foreach (wcount[i]) wcount[i] = 0;
        for (int i = 0; i < N; i++) begin
            n[i] = 0;
            set_req(i, AW'(8 + i), dat(i, 0), 1'b0);
        end
        for (int g = 0; g < 14; g++) push(AW'(8 + g % 3), dat(g % 3, g / 3), 1'b0);
        req_valid = 3'b111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k > 0) chk("t4_ready", 64'(req_ready), 64'(3'b001 << ((k - 1) % 3)));
            if (k >= 2) chk("t4_nogap", 64'(reg_write_out), 64'd1);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    n[i]++;
                    set_req(i, AW'(8 + i), dat(i, n[i]), 1'b0);
                end
            end
        end
        req_valid = '0;
        @(negedge clk);
        chk("t4_nogap", 64'(reg_write_out), 64'd1);
        @(negedge clk);
        chk("t4_nogap", 64'(reg_write_out), 64'd1);
        #1;
        chk("t4_fair0", 64'(wcount[8]), 64'd4);
        chk("t4_fair1", 64'(wcount[9]), 64'd4);
        chk("t4_fair2", 64'(wcount[10]), 64'd4);
        repeat (3) @(negedge clk);
        chk("t4_busy_end", 64'(busy), 64'd0);
        chk("t4_q_empty",  64'(exp_q.size()), 64'd0);

        // Null write to r0 is swallowed; overflow-only write to r0 is not.
        @(posedge clk); #1;
        set_req(1, 5'd0, 32'hDEAD, 1'b0);
        req_valid = 3'b010;
        @(negedge clk);
        chk("t5_null_ready", 64'(req_ready), 64'(3'b111));
        @(posedge clk); #1 req_valid = '0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_null_pm",   64'(pending_mask), 64'd0);
            chk("t5_null_we",   64'(reg_write_out), 64'd0);
            chk("t5_null_busy", 64'(busy), 64'd0);
        end
        @(posedge clk); #1;
        set_req(1, 5'd0, 32'h0000_00FF, 1'b1);
        req_valid = 3'b010;
        push(5'd0, 32'h0000_00FF, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("t5_ovf_pm_slot", 64'(pending_mask), 64'h4000_0000);
        chk("t5_ovf_we_e0",   64'(reg_write_out), 64'd0);
        @(negedge clk);
        chk("t5_ovf_we",  64'(reg_write_out), 64'd1);
        chk("t5_ovf_flag", 64'(overflow_out), 64'd1);
        chk("t5_ovf_pm",  64'(pending_mask), 64'h4000_0000);
        @(negedge clk);
        chk("t5_ovf_we_off",  64'(reg_write_out), 64'd0);
        chk("t5_ovf_flag_off", 64'(overflow_out), 64'd0);
        chk("t5_ovf_pm_off",  64'(pending_mask), 64'd0);

        // Mid-operation reset with slots 0 and 2 loaded (rr_ptr is 2 here).
        @(posedge clk); #1;
        set_req(0, 5'd4, 32'hB0, 1'b0);
        set_req(2, 5'd6, 32'hB2, 1'b0);
        req_valid = 3'b101;
        @(posedge clk); #1 req_valid = '0;
        chk("t6_pre_pm",    64'(pending_mask), 64'h0000_0050);
        chk("t6_pre_busy",  64'(busy), 64'd1);
        chk("t6_pre_ready", 64'(req_ready), 64'(3'b110));
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_we",    64'(reg_write_out), 64'd0);
        chk("t6_rst_wreg",  64'(write_reg_out), 64'd0);
        chk("t6_rst_wdata", 64'(write_data_out), 64'd0);
        chk("t6_rst_ovf",   64'(overflow_out), 64'd0);
        chk("t6_rst_pm",    64'(pending_mask), 64'd0);
        chk("t6_rst_busy",  64'(busy), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'(3'b111));
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_write", 64'(reg_write_out), 64'd0);
        end
        @(posedge clk); #1;
        set_req(0, 5'd11, 32'hD0, 1'b0);
        set_req(2, 5'd13, 32'hD2, 1'b0);
        req_valid = 3'b101;
        push(5'd11, 32'hD0, 1'b0);
        push(5'd13, 32'hD2, 1'b0);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(negedge clk);
        chk("t6_q_empty", 64'(exp_q.size()), 64'd0);

        // Same-requester ordering under contention; pm[7] covers A through B.
        @(posedge clk); #1;
        n0 = 0; n2 = 0;
        set_req(0, 5'd12, dat(0, 0), 1'b0);
        set_req(2, 5'd7, 32'hAAAA_0001, 1'b0);
        req_valid = 3'b101;
        push(5'd12, dat(0, 0), 1'b0);
        push(5'd7, 32'hAAAA_0001, 1'b0);
        push(5'd12, dat(0, 1), 1'b0);
        push(5'd7, 32'hBBBB_0002, 1'b0);
        push(5'd12, dat(0, 2), 1'b0);
        push(5'd12, dat(0, 3), 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 1) chk("t7_pm7_held", 64'(pending_mask[7]), 64'd1);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            if (acc[0]) begin
                n0++;
                set_req(0, 5'd12, dat(0, n0), 1'b0);
            end
            if (acc[2]) begin
                n2++;
                if (n2 == 1) set_req(2, 5'd7, 32'hBBBB_0002, 1'b0);
                else req_valid[2] = 1'b0;
            end
        end
        req_valid = '0;
        @(negedge clk);
        chk("t7_pm7_clear", 64'(pending_mask[7]), 64'd0);
        repeat (3) @(negedge clk);
        chk("t7_busy_end", 64'(busy), 64'd0);
        chk("t7_q_empty",  64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
